// File: rtl/hrm_io_pkg.sv
// hrm_io_pkg: shared definitions for the hrmcpu host byte-stream bridge.
//   - command bytes received from the host (CMD_*)
//   - reply bytes sent back to the host (RSP_*)
//   - bridge FSM state enum (dump states exist only with HRM_IO_BRIDGE_DUMP_EN)
package hrm_io_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_READ = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_MORE = 8'h01;
  localparam logic [7:0] RSP_END  = 8'h00;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LD_LEN  = 4'd1,
    LD_DATA = 4'd2,
    RD_CHK  = 4'd3,
    RD_TAG  = 4'd4,
    RD_DATA = 4'd5,
    RD_WAIT = 4'd6,
    STEP    = 4'd7,
    REPLY   = 4'd8
`ifdef HRM_IO_BRIDGE_DUMP_EN
    ,
    DMP_SEL  = 4'd9,
    DMP_WAIT = 4'd10,
    DMP_TAG  = 4'd11,
    DMP_DATA = 4'd12
`endif
  } state_t;

endpackage

// File: rtl/hrm_io_txreg.sv
// hrm_io_txreg: single-entry holding register for reply bytes.
// Ports:
//   clk, i_rst     clock, synchronous active-low reset (drops any pending byte)
//   load           write load_data into the register (only when free=1)
//   load_data      byte to send
//   tx_ready       host accepts the byte this cycle
//   tx_data        held byte, stable while tx_valid=1 and tx_ready=0
//   tx_valid       a byte is pending
//   free           a load this cycle is safe: empty, or the held byte leaves now
// Handshake: a byte transfers on a cycle where tx_valid & tx_ready. A load in
// the same cycle as an accept replaces the leaving byte, so back-to-back
// replies stream at one byte per cycle.
module hrm_io_txreg (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       free
);

  assign free = ~tx_valid | tx_ready;

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_data;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hrm_io_bridge.sv
// hrm_io_bridge: host command parser in front of the hrmcpu core.
// Commands (decoded in IDLE): 0x4C LOAD n bytes -> INBOX, reply 0x06;
// 0x52 READ drains OUTBOX as {0x01,byte}* then 0x00; 0x53 STEP pulses
// cpu_nxtInstr then replies 0x06; anything else replies 0x3F.
// Optional macro HRM_IO_BRIDGE_DUMP_EN adds 0x44 DUMP <sel>: scans FIFO
// positions 0..DMP_DEPTH-1 without popping, {0x01,byte}* then 0x00.
// Ports:
//   clk, i_rst                    clock, synchronous active-low reset
//   rx_data/rx_valid/rx_ready     host -> bridge byte stream
//   tx_data/tx_valid/tx_ready     bridge -> host reply stream
//   cpu_in_data/wr/full           INBOX push side
//   cpu_out_data/rd/empty         OUTBOX pop side
//   cpu_nxtInstr                  one-cycle step pulse
//   cpu_fifo_dmp_pos/sel/data/valid  FIFO dump port (tied 0 without the macro)
//   busy                          FSM not in IDLE
//   dbg_state                     current FSM state
// Streams follow valid/ready: a byte moves on a cycle with valid & ready;
// a producer holds valid and data stable until it is accepted.
module hrm_io_bridge
  import hrm_io_pkg::*;
#(
  parameter int DMP_DEPTH = 32
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] cpu_in_data,
  output logic       cpu_in_wr,
  input  logic       cpu_in_full,
  input  logic [7:0] cpu_out_data,
  output logic       cpu_out_rd,
  input  logic       cpu_out_empty,
  output logic       cpu_nxtInstr,
  output logic [4:0] cpu_fifo_dmp_pos,
  output logic       cpu_fifo_sel,
  input  logic [7:0] cpu_fifo_dmp_data,
  input  logic       cpu_fifo_dmp_valid,
  output logic       busy,
  output logic [3:0] dbg_state
);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;   // remaining LOAD payload bytes
  logic [7:0] rsp_q, rsp_d;   // final reply byte emitted from REPLY
  logic       rx_fire;
  logic       tx_load, tx_free;
  logic [7:0] tx_load_data;

`ifdef HRM_IO_BRIDGE_DUMP_EN
  localparam logic [4:0] DMP_LAST = 5'(DMP_DEPTH - 1);
  logic [4:0] pos_q, pos_d;
  logic       sel_q, sel_d;
  logic [7:0] dmp_q, dmp_d;
  assign cpu_fifo_dmp_pos = pos_q;
  assign cpu_fifo_sel     = sel_q;
`else
  localparam int unused_depth = DMP_DEPTH;
  logic unused_dmp;
  assign unused_dmp       = ^{cpu_fifo_dmp_data, cpu_fifo_dmp_valid};
  assign cpu_fifo_dmp_pos = 5'd0;
  assign cpu_fifo_sel     = 1'b0;
`endif

  assign rx_fire     = rx_valid & rx_ready;
  assign cpu_in_data = rx_data;
  assign dbg_state   = state_q;

  hrm_io_txreg u_txreg (
    .clk       (clk),
    .i_rst     (i_rst),
    .load      (tx_load),
    .load_data (tx_load_data),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .free      (tx_free)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rsp_q   <= 8'd0;
`ifdef HRM_IO_BRIDGE_DUMP_EN
      pos_q   <= 5'd0;
      sel_q   <= 1'b0;
      dmp_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
`ifdef HRM_IO_BRIDGE_DUMP_EN
      pos_q   <= pos_d;
      sel_q   <= sel_d;
      dmp_q   <= dmp_d;
`endif
    end
  end

  // Next-state logic. States that emit a byte only move on when the tx
  // register can take it, so nothing runs ahead of a pending reply.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
`ifdef HRM_IO_BRIDGE_DUMP_EN
    pos_d   = pos_q;
    sel_d   = sel_q;
    dmp_d   = dmp_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          case (rx_data)
            CMD_LOAD: state_d = LD_LEN;
            CMD_READ: state_d = RD_CHK;
            CMD_STEP: state_d = STEP;
`ifdef HRM_IO_BRIDGE_DUMP_EN
            CMD_DUMP: state_d = DMP_SEL;
`endif
            default: begin
              rsp_d   = RSP_ERR;
              state_d = REPLY;
            end
          endcase
        end
      end
      LD_LEN: begin
        if (rx_fire) begin
          if (rx_data == 8'd0) begin
            rsp_d   = RSP_ACK;
            state_d = REPLY;
          end else begin
            cnt_d   = rx_data;
            state_d = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (cpu_in_wr) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            rsp_d   = RSP_ACK;
            state_d = REPLY;
          end
        end
      end
      RD_CHK: begin
        // Non-empty but tx busy: RD_TAG remembers the decision to emit 0x01.
        if (cpu_out_empty) begin
          if (tx_free) state_d = IDLE;
        end else begin
          state_d = tx_free ? RD_DATA : RD_TAG;
        end
      end
      RD_TAG:  if (tx_free) state_d = RD_DATA;
      RD_DATA: if (tx_free) state_d = RD_WAIT;
      RD_WAIT: state_d = RD_CHK;
      STEP: begin
        rsp_d   = RSP_ACK;
        state_d = REPLY;
      end
      REPLY: if (tx_free) state_d = IDLE;
`ifdef HRM_IO_BRIDGE_DUMP_EN
      DMP_SEL: begin
        if (rx_fire) begin
          sel_d   = rx_data[0];
          pos_d   = 5'd0;
          state_d = DMP_WAIT;
        end
      end
      DMP_WAIT: state_d = DMP_TAG;
      DMP_TAG: begin
        if (tx_free) begin
          if (cpu_fifo_dmp_valid) begin
            dmp_d   = cpu_fifo_dmp_data;
            state_d = DMP_DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DMP_DATA: begin
        if (tx_free) begin
          if (pos_q == DMP_LAST) begin
            rsp_d   = RSP_END;
            state_d = REPLY;
          end else begin
            pos_d   = pos_q + 5'd1;
            state_d = DMP_WAIT;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Everything is held low while reset is asserted so the
  // outputs show reset values even before the first reset edge.
  always_comb begin
    rx_ready     = 1'b0;
    cpu_in_wr    = 1'b0;
    cpu_out_rd   = 1'b0;
    cpu_nxtInstr = 1'b0;
    tx_load      = 1'b0;
    tx_load_data = RSP_END;
    busy         = (state_q != IDLE);
    case (state_q)
      IDLE, LD_LEN: rx_ready = 1'b1;
      LD_DATA: begin
        rx_ready  = ~cpu_in_full;
        cpu_in_wr = rx_valid & ~cpu_in_full;
      end
      RD_CHK: begin
        tx_load      = tx_free;
        tx_load_data = cpu_out_empty ? RSP_END : RSP_MORE;
      end
      RD_TAG: begin
        tx_load      = tx_free;
        tx_load_data = RSP_MORE;
      end
      RD_DATA: begin
        // Capture and pop in the same cycle; the pop waits with the load.
        tx_load      = tx_free;
        tx_load_data = cpu_out_data;
        cpu_out_rd   = tx_free;
      end
      STEP: cpu_nxtInstr = 1'b1;
      REPLY: begin
        tx_load      = tx_free;
        tx_load_data = rsp_q;
      end
`ifdef HRM_IO_BRIDGE_DUMP_EN
      DMP_SEL: rx_ready = 1'b1;
      DMP_TAG: begin
        tx_load      = tx_free;
        tx_load_data = cpu_fifo_dmp_valid ? RSP_MORE : RSP_END;
      end
      DMP_DATA: begin
        tx_load      = tx_free;
        tx_load_data = dmp_q;
      end
`endif
      default: ;
    endcase
    if (!i_rst) begin
      rx_ready     = 1'b0;
      cpu_in_wr    = 1'b0;
      cpu_out_rd   = 1'b0;
      cpu_nxtInstr = 1'b0;
      tx_load      = 1'b0;
      busy         = 1'b0;
    end
  end

endmodule

// File: tb/tb_hrm_io_bridge.sv
// tb_hrm_io_bridge: directed + randomized bench for hrm_io_bridge. The bench
// plays host and CPU: it owns the INBOX/OUTBOX contents as queues, predicts
// reply streams from the command rules, and checks them as bytes leave tx.
module tb_hrm_io_bridge;

  localparam int DMP_DEPTH = 32;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] cpu_in_data;
  logic       cpu_in_wr;
  logic       cpu_in_full = 1'b0;
  logic [7:0] cpu_out_data = 8'h00;
  logic       cpu_out_rd;
  logic       cpu_out_empty = 1'b1;
  logic       cpu_nxtInstr;
  logic [4:0] cpu_fifo_dmp_pos;
  logic       cpu_fifo_sel;
  logic [7:0] cpu_fifo_dmp_data = 8'h00;
  logic       cpu_fifo_dmp_valid = 1'b0;
  logic       busy;
  logic [3:0] dbg_state;

  hrm_io_bridge #(.DMP_DEPTH(DMP_DEPTH)) dut (
    .clk(clk), .i_rst(i_rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpu_in_data(cpu_in_data), .cpu_in_wr(cpu_in_wr), .cpu_in_full(cpu_in_full),
    .cpu_out_data(cpu_out_data), .cpu_out_rd(cpu_out_rd), .cpu_out_empty(cpu_out_empty),
    .cpu_nxtInstr(cpu_nxtInstr),
    .cpu_fifo_dmp_pos(cpu_fifo_dmp_pos), .cpu_fifo_sel(cpu_fifo_sel),
    .cpu_fifo_dmp_data(cpu_fifo_dmp_data), .cpu_fifo_dmp_valid(cpu_fifo_dmp_valid),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Scoreboard state
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];      // expected tx bytes, in order
  logic [7:0] exp_inbox[$];  // expected INBOX contents
  logic [7:0] inbox_q[$];    // CPU INBOX as seen by the CPU
  logic [7:0] outbox_q[$];   // CPU OUTBOX
  int nxt_cnt = 0;
  int rd_cnt = 0;
  int tx_mode = 0;           // 0 ready, 1 toggle, 2 random, 3 stalled
  bit rand_full = 1'b0;
  bit force_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CPU model + tx monitor: sample at negedge, apply FIFO effects just after
  // the following posedge so the DUT sees them in the next cycle.
  bit         prev_hold = 1'b0;
  logic [7:0] prev_txd = 8'h00;
  bit         prev_nxt = 1'b0;
  bit         prev_rd = 1'b0;
  bit         tog = 1'b0;
  initial begin
    bit s_push, s_pop, s_hs;
    logic [7:0] s_pd, s_txd, e;
    forever begin
      @(negedge clk);
      s_push = cpu_in_wr; s_pd = cpu_in_data; s_pop = cpu_out_rd;
      s_hs = tx_valid & tx_ready; s_txd = tx_data;
      if (i_rst && prev_hold) begin
        chk("tx_hold_valid", 32'(tx_valid), 32'd1);
        chk("tx_hold_data", 32'(tx_data), 32'(prev_txd));
      end
      prev_hold = i_rst && tx_valid && !tx_ready;
      prev_txd = tx_data;
      if (cpu_nxtInstr) begin nxt_cnt++; chk("nxt_width", 32'(prev_nxt), 32'd0); end
      if (cpu_out_rd) begin
        rd_cnt++;
        chk("rd_width", 32'(prev_rd), 32'd0);
        chk("rd_nonempty", 32'(outbox_q.size() != 0), 32'd1);
      end
      prev_nxt = cpu_nxtInstr;
      prev_rd = cpu_out_rd;
      @(posedge clk);
      #2;
      if (s_push) inbox_q.push_back(s_pd);
      if (s_pop && outbox_q.size() != 0) void'(outbox_q.pop_front());
      if (s_hs) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL tx_extra: observed %02h expected no byte", s_txd);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'(s_txd), 32'(e));
        end
      end
      cpu_out_empty = (outbox_q.size() == 0);
      cpu_out_data = (outbox_q.size() != 0) ? outbox_q[0] : 8'h00;
      if (cpu_fifo_sel) begin
        cpu_fifo_dmp_valid = (int'(cpu_fifo_dmp_pos) < outbox_q.size());
        cpu_fifo_dmp_data = cpu_fifo_dmp_valid ? outbox_q[cpu_fifo_dmp_pos] : 8'h00;
      end else begin
        cpu_fifo_dmp_valid = (int'(cpu_fifo_dmp_pos) < inbox_q.size());
        cpu_fifo_dmp_data = cpu_fifo_dmp_valid ? inbox_q[cpu_fifo_dmp_pos] : 8'h00;
      end
      cpu_in_full = force_full | (rand_full & ($urandom_range(0, 2) == 0));
      tog = ~tog;
      case (tx_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = tog;
        2: tx_ready = ($urandom_range(0, 1) == 1);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks (all start and end 1 time unit after a posedge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (rx_ready) ok = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    if (!ok) chk("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      @(negedge clk);
      done = !busy && !tx_valid && (exp_q.size() == 0);
    end
    tick();
    chk("idle_reached", 32'(done), 32'd1);
  endtask

  task automatic check_inbox();
    chk("inbox_size", 32'(inbox_q.size()), 32'(exp_inbox.size()));
    for (int i = 0; i < exp_inbox.size() && i < inbox_q.size(); i++)
      chk("inbox_byte", 32'(inbox_q[i]), 32'(exp_inbox[i]));
  endtask

  task automatic do_load(input int n);
    logic [7:0] b;
    send_byte(8'h4C);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_inbox.push_back(b);
      send_byte(b);
    end
    exp_q.push_back(8'h06);
    wait_idle();
    check_inbox();
  endtask

  task automatic do_read();
    int r0 = rd_cnt;
    int sz = outbox_q.size();
    foreach (outbox_q[i]) begin
      exp_q.push_back(8'h01);
      exp_q.push_back(outbox_q[i]);
    end
    exp_q.push_back(8'h00);
    send_byte(8'h52);
    wait_idle();
    chk("read_pops", 32'(rd_cnt - r0), 32'(sz));
    chk("outbox_drained", 32'(outbox_q.size()), 32'd0);
  endtask

  task automatic do_step();
    int n0 = nxt_cnt;
    exp_q.push_back(8'h06);
    send_byte(8'h53);
    wait_idle();
    chk("step_pulses", 32'(nxt_cnt - n0), 32'd1);
  endtask

  task automatic do_bad(input logic [7:0] c);
    exp_q.push_back(8'h3F);
    send_byte(c);
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_in_wr"}, 32'(cpu_in_wr), 32'd0);
    chk({tag, "_out_rd"}, 32'(cpu_out_rd), 32'd0);
    chk({tag, "_nxt"}, 32'(cpu_nxtInstr), 32'd0);
    chk({tag, "_dmp_pos"}, 32'(cpu_fifo_dmp_pos), 32'd0);
    chk({tag, "_sel"}, 32'(cpu_fifo_sel), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

`ifdef HRM_IO_BRIDGE_DUMP_EN
  task automatic do_dump(input logic [7:0] selb);
    logic [7:0] snap[$];
    snap = selb[0] ? outbox_q : inbox_q;
    for (int i = 0; i < snap.size() && i < DMP_DEPTH; i++) begin
      exp_q.push_back(8'h01);
      exp_q.push_back(snap[i]);
    end
    exp_q.push_back(8'h00);
    send_byte(8'h44);
    send_byte(selb);
    wait_idle();
    if (selb[0]) begin
      chk("dump_outbox_size", 32'(outbox_q.size()), 32'(snap.size()));
      foreach (snap[i]) chk("dump_outbox_keep", 32'(outbox_q[i]), 32'(snap[i]));
    end else begin
      chk("dump_inbox_size", 32'(inbox_q.size()), 32'(snap.size()));
      foreach (snap[i]) chk("dump_inbox_keep", 32'(inbox_q[i]), 32'(snap[i]));
    end
  endtask
`endif

  // Directed sequence
  initial begin
    logic [7:0] b1, c;
    int kind;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    i_rst = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_reset", 32'(rx_ready), 32'd1);
    tick();

    // LOAD 3 bytes
    exp_inbox.push_back(8'h0A); exp_inbox.push_back(8'hFF); exp_inbox.push_back(8'h80);
    exp_q.push_back(8'h06);
    send_byte(8'h4C); send_byte(8'h03);
    send_byte(8'h0A); send_byte(8'hFF); send_byte(8'h80);
    wait_idle();
    check_inbox();
    chk("busy_after_load", 32'(busy), 32'd0);

    // LOAD 2 with a 5-cycle INBOX-full stall on the second byte
    b1 = 8'($urandom_range(0, 255));
    exp_inbox.push_back(b1);
    send_byte(8'h4C); send_byte(8'h02); send_byte(b1);
    b1 = 8'($urandom_range(0, 255));
    exp_inbox.push_back(b1);
    force_full = 1'b1;
    rx_data = b1;
    rx_valid = 1'b1;
    tick();
    repeat (5) begin
      @(negedge clk);
      chk("stall_rx_ready", 32'(rx_ready), 32'd0);
      chk("stall_in_wr", 32'(cpu_in_wr), 32'd0);
      tick();
    end
    force_full = 1'b0;
    exp_q.push_back(8'h06);
    send_byte(b1);
    wait_idle();
    check_inbox();

    // LOAD N=0
    do_load(0);

    // READ with tx_ready toggling
    outbox_q.push_back(8'h05); outbox_q.push_back(8'h00);
    tx_mode = 1;
    tick(); tick();
    do_read();
    tx_mode = 0;
    do_read();   // empty OUTBOX -> single 0x00

    do_step();
    do_bad(8'h7E);

    // Reset in the middle of a LOAD payload
    b1 = 8'($urandom_range(0, 255));
    exp_inbox.push_back(b1);
    send_byte(8'h4C); send_byte(8'h03); send_byte(b1);
    i_rst = 1'b0;
    tick();
    @(negedge clk);
    check_reset_outputs("midload_rst");
    tick();
    i_rst = 1'b1;
    tick();
    check_inbox();
    do_step();

    // Pending reply byte dropped by reset
    tx_mode = 3;
    send_byte(8'h7E);
    repeat (3) tick();
    @(negedge clk);
    chk("pending_tx_valid", 32'(tx_valid), 32'd1);
    chk("pending_tx_data", 32'(tx_data), 32'h3F);
    tick();
    i_rst = 1'b0;
    tick();
    @(negedge clk);
    chk("drop_tx_valid", 32'(tx_valid), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    tick();
    i_rst = 1'b1;
    tx_mode = 0;
    tick();

    // Randomized command mix
    for (int it = 0; it < 30; it++) begin
      tx_mode = $urandom_range(0, 2);
      rand_full = ($urandom_range(0, 1) == 1);
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_load($urandom_range(0, 6));
        1: begin
          for (int k = $urandom_range(0, 4); k > 0; k--)
            outbox_q.push_back(8'($urandom_range(0, 255)));
          tick(); tick();
          do_read();
        end
        2: do_step();
        default: begin
          c = 8'($urandom_range(0, 255));
          while (c == 8'h4C || c == 8'h52 || c == 8'h53 || c == 8'h44)
            c = 8'($urandom_range(0, 255));
          do_bad(c);
        end
      endcase
    end
    tx_mode = 0;
    rand_full = 1'b0;
    tick(); tick();

`ifdef HRM_IO_BRIDGE_DUMP_EN
    inbox_q.delete();
    inbox_q.push_back(8'h11); inbox_q.push_back(8'h22);
    tick(); tick();
    do_dump(8'h00);
    outbox_q.delete();
    repeat (3) outbox_q.push_back(8'($urandom_range(0, 255)));
    tick(); tick();
    tx_mode = 2;
    do_dump(8'hA5);
    tx_mode = 0;
    inbox_q.delete();
    repeat (DMP_DEPTH) inbox_q.push_back(8'($urandom_range(0, 255)));
    tick(); tick();
    do_dump(8'h00);
    outbox_q.delete();
    tick(); tick();
`else
    do_bad(8'h44);
    chk("nodump_pos", 32'(cpu_fifo_dmp_pos), 32'd0);
    chk("nodump_sel", 32'(cpu_fifo_sel), 32'd0);
`endif

    repeat (4) tick();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hrm_io_bridge.md
# hrm_io_bridge

Host-side byte-stream bridge placed in front of the `hrmcpu` core. It parses a simple command protocol arriving on a valid/ready receive stream. It pushes LOAD payloads into the CPU INBOX, drains the CPU OUTBOX back onto a valid/ready transmit stream, and issues single-step pulses. It is the only producer on `cpu_in_*` and the only consumer on `cpu_out_*`.

## Interface
Parameters:
- `DMP_DEPTH`, default 32: FIFO dump positions scanned; matches the FIFO depth `2**LGFLEN`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `i_rst`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  host command/payload byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  bridge accepts `rx_data` this cycle.
- `tx_data`  out  8  reply byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  host accepts `tx_data`.
- `cpu_in_data`  out  8  byte to INBOX.
- `cpu_in_wr`  out  1  INBOX push strobe.
- `cpu_in_full`  in  1  INBOX full.
- `cpu_out_data`  in  8  OUTBOX head byte, valid while `cpu_out_empty`=0.
- `cpu_out_rd`  out  1  OUTBOX pop strobe.
- `cpu_out_empty`  in  1  OUTBOX empty.
- `cpu_nxtInstr`  out  1  one-cycle step pulse to CPU.
- `cpu_fifo_dmp_pos`  out  5  dump position.
- `cpu_fifo_sel`  out  1  dump FIFO select: 0 INBOX, 1 OUTBOX.
- `cpu_fifo_dmp_data`  in  8  dump data.
- `cpu_fifo_dmp_valid`  in  1  dump position valid.
- `busy`  out  1  FSM not in IDLE.

## Operation
- A byte transfers on rx when `rx_valid & rx_ready`, and on tx when `tx_valid & tx_ready`.
- Commands, decoded in IDLE:
  - `0x4C` LOAD: next byte is N, followed by N payload bytes pushed to INBOX in order. After the last byte, reply `0x06`. N=0 replies `0x06` immediately.
  - `0x52` READ: while the OUTBOX is not empty, emit `0x01` followed by the head byte, then pop. When the OUTBOX is empty, emit `0x00` and return to IDLE. An empty OUTBOX gives the single reply `0x00`.
  - `0x53` STEP: drive `cpu_nxtInstr` high for exactly one cycle, then reply `0x06`.
  - Any other byte: reply `0x3F`.
- FSM states: IDLE, LD_LEN, LD_DATA, RD_CHK, RD_TAG, RD_DATA, RD_WAIT, STEP, REPLY; with the dump feature, also DMP_SEL, DMP_WAIT, DMP_TAG, DMP_DATA.
- `rx_ready`:
  - always 1 in IDLE, LD_LEN and DMP_SEL;
  - in LD_DATA, equals `~cpu_in_full`;
  - 0 in every other state.
- `cpu_in_wr = rx_valid & ~cpu_in_full` while in LD_DATA, and `cpu_in_data = rx_data` (combinational). A full INBOX stalls the host, which is never dropped.
- The payload counter is 8 bits and counts down. Leave LD_DATA on the push when the counter equals 1.
- In RD_DATA, capture `cpu_out_data` into the tx register and assert `cpu_out_rd` for one cycle together. RD_WAIT then lets the empty flag settle before the next RD_CHK.
- Every reply byte goes through a single tx holding register. `tx_valid` stays asserted and `tx_data` stays stable until accepted. No state advances past a pending tx byte.

## Timing
- Reset values: `rx_ready`=0, `tx_valid`=0, `tx_data`=0, `cpu_in_wr`=0, `cpu_out_rd`=0, `cpu_nxtInstr`=0, `cpu_fifo_dmp_pos`=0, `cpu_fifo_sel`=0, `busy`=0; the FSM is in IDLE.
- `rx_ready` is 1 in the first cycle after reset release.
- A reset mid-operation aborts immediately. Bytes already pushed stay in the INBOX, and any pending tx byte is dropped.
- Command decode to first tx byte: 1 cycle.
- READ throughput: 3 cycles per OUTBOX byte (RD_CHK/RD_TAG, RD_DATA, RD_WAIT), plus any tx stalls.
- `cpu_out_rd` and `cpu_nxtInstr` never stay high two consecutive cycles.
- LOAD with a continuously valid rx and a non-full INBOX pushes 1 byte per cycle.

## Configuration
- Macro `HRM_IO_BRIDGE_DUMP_EN` defined:
  - Adds command `0x44` DUMP, whose next byte bit0 sets `cpu_fifo_sel`.
  - Scans positions 0..`DMP_DEPTH`-1. For each position: set `cpu_fifo_dmp_pos`, wait one cycle (DMP_WAIT), then sample.
  - If `cpu_fifo_dmp_valid`=1, emit `0x01` followed by the data byte. At the first invalid position or at the end of the scan, emit `0x00`.
  - Dump does not pop either FIFO.
- Macro undefined: the dump states are absent, `cpu_fifo_dmp_pos` and `cpu_fifo_sel` are tied to 0, and `0x44` replies `0x3F`.

## Structure
- Shared package `hrm_io_pkg` holds:
  - command bytes `CMD_LOAD`, `CMD_READ`, `CMD_STEP`, `CMD_DUMP`;
  - reply bytes `RSP_ACK`=`0x06`, `RSP_MORE`=`0x01`, `RSP_END`=`0x00`, `RSP_ERR`=`0x3F`;
  - the FSM state enum.
- One sub-module, `hrm_io_txreg`: the single-entry tx holding register with load/accept handshake.

## Test plan
- Reset, then `0x4C 0x03 0x0A 0xFF 0x80` → INBOX receives 0x0A, 0xFF, 0x80 in order; tx emits `0x06`; `busy` returns to 0.
- LOAD N=2 with `cpu_in_full` forced high for 5 cycles on the second byte → `rx_ready`=0 and `cpu_in_wr`=0 during the stall; the byte is pushed exactly once after release.
- OUTBOX holds 0x05, 0x00; send `0x52` with `tx_ready` toggling every other cycle → tx stream `01 05 01 00 00`; exactly two `cpu_out_rd` pulses.
- `0x53` → one-cycle `cpu_nxtInstr` pulse, then `0x06`; `0x7E` → `0x3F`.
- Assert `i_rst` low in the middle of the LOAD payload (after 1 of 3 bytes) → all outputs at their reset values next cycle; a following `0x53` behaves normally.
- With `HRM_IO_BRIDGE_DUMP_EN`, INBOX holding 0x11, 0x22, send `0x44 0x00` → tx stream `01 11 01 22 00`; INBOX contents unchanged.
